// File: rtl/div_32.sv
// Iterative signed divider: radix-2 restoring, one quotient bit per clock.
// Saturates on divide-by-zero and on MIN / -1; fixed WIDTH+1 cycle latency.
module div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic             div_zero,
    output logic             sat
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_V  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] a_r, abs_b_r, rem_r, quo_r;
    logic             sign_q_r, sign_r_r, zero_r, ovf_r;
    logic [WIDTH+1:0] diff_s;

    // Magnitude as an unsigned WIDTH-bit value; MIN maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? (ZERO_V - v) : v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and trial subtraction
    always_comb begin
        state_s = state_r;
        diff_s  = {1'b0, rem_r, quo_r[WIDTH-1]} - {2'b00, abs_b_r};
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            DIV: begin
                if (count_r == CW'(WIDTH-1)) begin
                    state_s = FIN;
                end else begin
                    state_s = DIV;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, restoring iterations and result registration
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= {CW{1'b0}};
            a_r      <= ZERO_V;
            abs_b_r  <= ZERO_V;
            rem_r    <= ZERO_V;
            quo_r    <= ZERO_V;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Y        <= ZERO_V;
            R        <= ZERO_V;
            div_zero <= 1'b0;
            sat      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r      <= A;
                        abs_b_r  <= mag(B);
                        quo_r    <= mag(A);
                        rem_r    <= ZERO_V;
                        sign_q_r <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r_r <= A[WIDTH-1];
                        zero_r   <= (B == ZERO_V);
                        ovf_r    <= (A == MIN_V) && (B == ONES_V);
                        count_r  <= {CW{1'b0}};
                        busy     <= 1'b1;
                    end else begin
                        busy     <= 1'b0;
                    end
                end
                DIV: begin
                    done    <= 1'b0;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    // The dividend bits shift out of quo into rem as quotient bits shift in.
                    if (!diff_s[WIDTH+1]) begin
                        rem_r <= diff_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (zero_r) begin
                        Y        <= a_r[WIDTH-1] ? MIN_V : MAX_V;
                        R        <= a_r;
                        div_zero <= 1'b1;
                        sat      <= 1'b1;
                    end else if (ovf_r) begin
                        Y        <= MAX_V;
                        R        <= ZERO_V;
                        div_zero <= 1'b0;
                        sat      <= 1'b1;
                    end else begin
                        Y        <= sign_q_r ? (ZERO_V - quo_r) : quo_r;
                        R        <= sign_r_r ? (ZERO_V - rem_r) : rem_r;
                        div_zero <= 1'b0;
                        sat      <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: driver pushes model results, monitor checks each done.
module tb_div_32;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] A, B;
    logic        busy, done, div_zero, sat;
    logic [31:0] Y, R;

    div_32 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Y(Y), .R(R),
        .div_zero(div_zero), .sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] y;
        logic [31:0] r;
        logic        dz;
        logic        sat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    // Reference: plain signed arithmetic, with the saturation rules layered on top.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        int   sa, sb;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        e.acc = acc;
        e.dz  = 1'b0;
        e.sat = 1'b0;
        if (sb == 0) begin
            e.y   = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.sat = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.y   = 32'h7FFF_FFFF;
            e.r   = 32'h0;
            e.sat = 1'b1;
        end else begin
            e.y = 32'(sa / sb);
            e.r = 32'(sa % sb);
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            tests = tests + 1;
            if (sbq.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_done: got Y=%h R=%h at cyc %0d, no operation outstanding", Y, R, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (Y !== e.y || R !== e.r || div_zero !== e.dz || sat !== e.sat || cyc != e.acc + 33) begin
                    fails = fails + 1;
                    $display("FAIL result: got Y=%h R=%h dz=%b sat=%b cyc=%0d, expected Y=%h R=%h dz=%b sat=%b cyc=%0d",
                             Y, R, div_zero, sat, cyc, e.y, e.r, e.dz, e.sat, e.acc + 33);
                end
            end
        end
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge accepts the request.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        sbq.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL timeout: no done within 60 cycles (cyc %0d)", cyc);
        end
    endtask

    logic [31:0] ta [10] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd7,
                             32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h8000_0000};
    logic [31:0] tb_ [10] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0,
                              32'h0, 32'hFFFF_FFFF, 32'd2, 32'd9, 32'd1};

    initial begin
        int nb, n;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; A = 32'h0; B = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_state", {40'h0, 6'b0, busy, done, Y[15:0], R[7:0]} | {8'h0, Y, R},
              72'h0);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with busy-length check
        issue(32'd100, 32'd7);
        nb = 0; n = 0;
        while (!done && n < 60) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests = tests + 1; fails = fails + 1;
            $display("FAIL timeout: first op never completed");
        end
        check("busy_cycles", 72'(nb), 72'd33);
        @(negedge clk);

        // Directed sign, zero, overflow and MIN cases; every other one back-to-back with done
        for (int i = 0; i < 10; i++) begin
            issue(ta[i], tb_[i]);
            wait_done();
            if (i % 2 == 0) @(negedge clk);
        end

        // start pulse mid-operation must be ignored
        @(negedge clk);
        issue(32'd1000, 32'd3);
        repeat (8) @(negedge clk);
        A = 32'd5; B = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // start coincident with done
        issue(32'hFFFE_D02F, 32'd13);
        wait_done();
        repeat (40) @(negedge clk);

        // Reset mid-operation aborts with no done
        issue(32'd123456, 32'hFFFF_FFFB);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        check("reset_midop", {6'b0, busy, done, Y, R}, 72'h0);
        repeat (40) @(negedge clk);
        issue(32'd1000, 32'd10);
        wait_done();
        @(negedge clk);

        // Randomized operands with biased special cases
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'h0 - 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ra = ra >> $urandom_range(0, 31);
            endcase
            issue(ra, rb);
            wait_done();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 72'(sbq.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
